qreg_sipo_rx: RTL and testbench
===============================

Name: qreg_sipo_rx

Overview:
Serial-to-parallel receiver, the receiving end of the 4-bit shift-register link.
- The transmitter loads a word and shifts it out bit 0 first, one bit per shift cycle.
- This block collects those bits, rebuilds the word and presents it with a valid/ack handshake.
- It sits at the far end of the serial link and feeds a parallel consumer (display, ALU or register file).

Parameters:
- WIDTH, 4, number of bits per frame; must be at least 2.
- CNT_W, 3, width of the internal bit counter; must satisfy 2**CNT_W > WIDTH.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
- start  input  1  one-cycle frame-start strobe; that cycle carries no data bit.
- sen  input  1  shift enable; sdata is sampled on every clock where sen=1 while receiving.
- sdata  input  1  serial data bit, LSB first (same order in which the transmitter shifts its low bit out).
- ack  input  1  consumer accepts dout; only meaningful while valid=1.
- dout  output  WIDTH  received word; held stable while valid=1.
- valid  output  1  dout holds a complete frame.
- busy  output  1  frame reception in progress.
- overrun  output  1  sticky flag: a start arrived while an unacknowledged word was pending.

Behaviour:
- One clock domain. Reset is synchronous and active-high; all registers update only on the rising edge of clock.
- Reset (has priority over every other input, including mid-frame):
  - state=IDLE, shift register=0, counter=0.
  - dout=0, valid=0, busy=0, overrun=0.
- States: IDLE, RECV, FULL.
- IDLE:
  - valid=0, busy=0.
  - start=1 -> RECV, counter=0, shift register=0.
  - sen and sdata are ignored.
- RECV:
  - busy=1.
  - On each cycle with sen=1: shreg <= {sdata, shreg[WIDTH-1:1]}, counter <= counter+1.
    - The first bit received ends up in dout[0], the last in dout[WIDTH-1].
  - sen=0: shift register and counter hold; there is no timeout.
  - start=1 in RECV: abort the partial frame, clear counter and shift register, stay in RECV.
    - The sen/sdata of that cycle are ignored.
    - overrun is not affected.
  - When sen=1 and counter==WIDTH-1:
    - dout <= {sdata, shreg[WIDTH-1:1]}.
    - valid=1 and busy=0 from the next cycle; go to FULL.
    - Latency: valid rises on the clock edge that samples the WIDTH-th bit, so it is visible one cycle after that bit is presented.
- FULL:
  - valid=1, busy=0; dout is stable; sen and sdata are ignored.
  - ack=1, start=0 -> valid=0, go to IDLE. dout keeps its last value.
  - ack=1, start=1 in the same cycle -> valid=0, go directly to RECV (counter and shift register cleared). No overrun.
  - ack=0, start=1 -> set overrun=1. The start is dropped and the state stays FULL, so the pending word is never overwritten.
- overrun is cleared only by reset.
- ack outside FULL has no effect.
- Counter width is CNT_W. It never exceeds WIDTH-1 and is cleared on every frame start.
- busy and valid are never both 1.

Test Plan (WIDTH=4):
1. Basic frame:
   - reset 2 cycles, start pulse, then sen=1 with sdata 1,0,1,1 on consecutive cycles.
   - Required: busy=1 during reception; valid=1 and dout=4'b1101 one cycle after the 4th bit; busy=0.
   - ack=1 for one cycle -> valid=0, state IDLE, dout still 4'b1101.
2. Gapped enable:
   - start, then bits 0,1,1,0 with sen=0 gaps of 0, 2 and 3 cycles between them.
   - Required: dout=4'b0110, valid asserted only after the 4th sen=1 cycle.
3. Abort and restart:
   - start, 2 bits (1,1), start again, then 0,0,0,1.
   - Required: dout=4'b1000, overrun=0.
4. Overrun:
   - complete a frame (dout=4'hA), hold ack=0, pulse start.
   - Required: overrun=1, valid=1, dout=4'hA unchanged, state FULL.
   - ack -> valid=0, overrun stays 1.
5. Ack with start in the same cycle:
   - in FULL, assert ack=1 and start=1 together, then send 1,1,1,1.
   - Required: valid drops for exactly the reception window, next dout=4'hF, overrun=0.
6. Reset mid-frame:
   - start, 2 bits, then reset=1 for one cycle, then 4 bits with no start.
   - Required: all outputs 0 after reset; the bits are ignored (IDLE); valid stays 0.

Source files
------------

// File: rtl/qreg_sipo_rx.sv
// Serial-to-parallel receiver for the 4-bit shift-register link: collects LSB-first
// bits into a word and hands it to a parallel consumer through a valid/ack handshake.
module qreg_sipo_rx #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             sen,
  input  logic             sdata,
  input  logic             ack,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               overrun_q, overrun_d;
  logic [WIDTH-1:0]   shifted;

  assign shifted = {sdata, shreg_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    overrun_d = overrun_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RECV;
          shreg_d = '0;
          cnt_d   = '0;
        end
      end
      RECV: begin
        // A start mid-frame discards the partial word; its sen/sdata are ignored.
        if (start) begin
          shreg_d = '0;
          cnt_d   = '0;
        end else if (sen) begin
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            dout_d  = shifted;
            shreg_d = '0;
            cnt_d   = '0;
            state_d = FULL;
          end else begin
            shreg_d = shifted;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      FULL: begin
        if (ack) begin
          state_d = start ? RECV : IDLE;
          shreg_d = '0;
          cnt_d   = '0;
        end else if (start) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      dout_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      overrun_q <= overrun_d;
    end
  end

  assign dout    = dout_q;
  assign valid   = (state_q == FULL);
  assign busy    = (state_q == RECV);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_qreg_sipo_rx.sv
// Directed self-checking bench for qreg_sipo_rx (WIDTH=4); each check compares
// the packed vector {valid, busy, overrun, dout} against a hand-computed value.
module tb_qreg_sipo_rx;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clock;
  logic             reset;
  logic             start;
  logic             sen;
  logic             sdata;
  logic             ack;
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic             busy;
  logic             overrun;

  int checks;
  int failures;

  qreg_sipo_rx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .sen     (sen),
    .sdata   (sdata),
    .ack     (ack),
    .dout    (dout),
    .valid   (valid),
    .busy    (busy),
    .overrun (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge; outputs are then sampled 1ns after that edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sen   = 1'b1;
    sdata = b;
    tick();
    sen   = 1'b0;
    sdata = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_cycles(2);
    checks++;
    if ({valid, busy, overrun, dout} !== 7'b000_0000) begin
      failures++;
      $display("[TB] FAIL reset_state: got v/b/o/dout=%b want 0000000", {valid, busy, overrun, dout});
    end
    reset = 1'b0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if ({valid, busy, overrun, dout} !== 7'b000_0000) begin
      failures++;
      $display("[TB] FAIL ack_in_idle: got %b want 0000000", {valid, busy, overrun, dout});
    end
  endtask

  task automatic test_basic_frame();
    pulse_start();
    checks++;
    if ({valid, busy} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL basic_busy_after_start: got valid/busy=%b want 01", {valid, busy});
    end
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    checks++;
    if ({valid, busy} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL basic_busy_mid: got valid/busy=%b want 01", {valid, busy});
    end
    send_bit(1'b1);
    checks++;
    if ({valid, busy, overrun, dout} !== 7'b100_1101) begin
      failures++;
      $display("[TB] FAIL basic_done: got %b want 1001101", {valid, busy, overrun, dout});
    end
    pulse_ack();
    checks++;
    if ({valid, busy, overrun, dout} !== 7'b000_1101) begin
      failures++;
      $display("[TB] FAIL basic_after_ack: got %b want 0001101", {valid, busy, overrun, dout});
    end
  endtask

  task automatic test_gapped_enable();
    pulse_start();
    send_bit(1'b0);
    send_bit(1'b1);
    idle_cycles(2);
    checks++;
    if ({valid, busy} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL gapped_hold1: got valid/busy=%b want 01", {valid, busy});
    end
    send_bit(1'b1);
    idle_cycles(3);
    checks++;
    if ({valid, busy, dout} !== 6'b01_1101) begin
      failures++;
      $display("[TB] FAIL gapped_hold2: got valid/busy/dout=%b want 011101", {valid, busy, dout});
    end
    send_bit(1'b0);
    checks++;
    if ({valid, busy, overrun, dout} !== 7'b100_0110) begin
      failures++;
      $display("[TB] FAIL gapped_done: got %b want 1000110", {valid, busy, overrun, dout});
    end
    pulse_ack();
  endtask

  task automatic test_abort_restart();
    pulse_start();
    send_bit(1'b1);
    send_bit(1'b1);
    // The restart cycle also presents sen=1/sdata=1, which must be dropped.
    start = 1'b1;
    sen   = 1'b1;
    sdata = 1'b1;
    tick();
    start = 1'b0;
    sen   = 1'b0;
    sdata = 1'b0;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    checks++;
    if ({valid, busy} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL abort_not_early: got valid/busy=%b want 01", {valid, busy});
    end
    send_bit(1'b1);
    checks++;
    if ({valid, busy, overrun, dout} !== 7'b100_1000) begin
      failures++;
      $display("[TB] FAIL abort_done: got %b want 1001000", {valid, busy, overrun, dout});
    end
    pulse_ack();
  endtask

  task automatic test_overrun();
    pulse_start();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    pulse_start();
    checks++;
    if ({valid, busy, overrun, dout} !== 7'b101_1010) begin
      failures++;
      $display("[TB] FAIL overrun_set: got %b want 1011010", {valid, busy, overrun, dout});
    end
    send_bit(1'b1);
    checks++;
    if ({valid, busy, overrun, dout} !== 7'b101_1010) begin
      failures++;
      $display("[TB] FAIL overrun_full_ignores_sen: got %b want 1011010", {valid, busy, overrun, dout});
    end
    pulse_ack();
    checks++;
    if ({valid, busy, overrun, dout} !== 7'b001_1010) begin
      failures++;
      $display("[TB] FAIL overrun_sticky: got %b want 0011010", {valid, busy, overrun, dout});
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({valid, busy, overrun, dout} !== 7'b000_0000) begin
      failures++;
      $display("[TB] FAIL overrun_reset_clear: got %b want 0000000", {valid, busy, overrun, dout});
    end
  endtask

  task automatic test_ack_with_start();
    pulse_start();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    checks++;
    if ({valid, busy, overrun, dout} !== 7'b100_0101) begin
      failures++;
      $display("[TB] FAIL ackstart_first: got %b want 1000101", {valid, busy, overrun, dout});
    end
    ack   = 1'b1;
    start = 1'b1;
    tick();
    ack   = 1'b0;
    start = 1'b0;
    checks++;
    if ({valid, busy, overrun} !== 3'b010) begin
      failures++;
      $display("[TB] FAIL ackstart_enter_recv: got valid/busy/overrun=%b want 010", {valid, busy, overrun});
    end
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    checks++;
    if ({valid, busy} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL ackstart_window: got valid/busy=%b want 01", {valid, busy});
    end
    send_bit(1'b1);
    checks++;
    if ({valid, busy, overrun, dout} !== 7'b100_1111) begin
      failures++;
      $display("[TB] FAIL ackstart_second: got %b want 1001111", {valid, busy, overrun, dout});
    end
    pulse_ack();
  endtask

  task automatic test_reset_mid_frame();
    pulse_start();
    send_bit(1'b1);
    send_bit(1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({valid, busy, overrun, dout} !== 7'b000_0000) begin
      failures++;
      $display("[TB] FAIL midreset_state: got %b want 0000000", {valid, busy, overrun, dout});
    end
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b1);
      checks++;
      if ({valid, busy, overrun, dout} !== 7'b000_0000) begin
        failures++;
        $display("[TB] FAIL midreset_ignore_bit%0d: got %b want 0000000", i, {valid, busy, overrun, dout});
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    sen      = 1'b0;
    sdata    = 1'b0;
    ack      = 1'b0;
    test_reset();
    test_basic_frame();
    test_gapped_enable();
    test_abort_restart();
    test_overrun();
    test_ack_with_start();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
